tx: RTL and testbench
=====================

# tx

DAC waveform burst transmitter. On a start request it plays a fixed 64-point sine table onto an 8-bit parallel DAC bus, holding each sample for a programmable number of clocks and repeating the table a programmable number of periods. It then signals completion with a one-cycle pulse. It sits between the control logic, which raises `enTx`, and the external DAC data pins (`dadata`).

## Interface
- `SAMPLE_DIV`, default 4: clocks each sample is held; legal range 1..256.
- `NUM_PERIODS`, default 2: full table periods per burst; legal range 1..256.
- `clk_100`  in  1  system clock, 100 MHz nominal; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enTx`  in  1  start request, level input; a burst launches on its registered rising edge.
- `overTx`  out  1  one-cycle burst-complete pulse.
- `dadata`  out  8  DAC sample, unsigned offset binary; mid-scale is 8'd128.

## Operation
- Sine ROM has 64 entries, k = 0..63: value = round(128 + 127·sin(2πk/64)).
  - k=0 → 128, k=16 → 255, k=32 → 128, k=48 → 1.
- Edge detect: register `en_d` captures `enTx` each clock, with reset value 0. A start is `enTx & ~en_d`.
  - If `enTx` is already high when reset deasserts, that counts as a start.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `dadata` = 128, `overTx` = 0.
  - On start → RUN, with idx=0, div_cnt=0, per_cnt=0.
- RUN:
  - `dadata` = ROM[idx].
  - div_cnt increments each clock. At SAMPLE_DIV-1 it clears and idx increments.
  - idx wraps 63→0 and per_cnt increments.
  - When div_cnt = SAMPLE_DIV-1, idx = 63 and per_cnt = NUM_PERIODS-1 → DONE.
  - Start edges during RUN are ignored; they are not queued.
- DONE:
  - `overTx` = 1, `dadata` = 128.
  - Next clock → IDLE.
- Counter widths: div_cnt and per_cnt are sized with $clog2(max(param,2)). idx is 6 bits.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Reset values, all driven the cycle after `rst` is sampled high:
  - `dadata` = 128, `overTx` = 0.
  - state = IDLE, `en_d` = 0, all counters 0.
- Reset asserted mid-burst aborts the burst immediately. No `overTx` pulse is produced.
- Start latency: `enTx` is first sampled high at edge N (with `en_d` = 0).
  - ROM[0] appears on `dadata` after edge N+1.
  - ROM[1] appears after edge N+1+SAMPLE_DIV.
- Burst length: 64·SAMPLE_DIV·NUM_PERIODS cycles of RUN. With defaults this is 512.
- `overTx` is high for exactly one cycle, immediately following the last RUN cycle. `dadata` returns to 128 in that same cycle.
- After DONE, a new burst requires `enTx` to fall and rise again, unless TX_AUTOREPEAT_EN is defined.
- Rise/fall of `enTx` inside a single RUN cycle has no effect. `en_d` still tracks `enTx`.

## Configuration
- Macro: `TX_AUTOREPEAT_EN`.
- Defined: in DONE, if `enTx` is currently 1, the next state is RUN with counters cleared, not IDLE.
  - `overTx` still pulses for one cycle per burst.
  - `dadata` shows 128 in the DONE cycle, then ROM[0].
  - Gap between bursts is exactly 1 cycle.
- Not defined: DONE always goes to IDLE. Holding `enTx` high yields exactly one burst.

## Test plan
- Reset: hold `rst`=1 for 5 clocks with `enTx`=0 → `dadata`=128 and `overTx`=0 throughout, and 100 cycles after release.
- Single burst, defaults: release reset, raise `enTx` 2 cycles later and hold high.
  - `dadata` sequence matches ROM, each value held 4 clocks; 16th sample = 255, 48th = 1.
  - 2 periods, 512 cycles in total.
  - `overTx`=1 for exactly 1 cycle, then `dadata`=128 and no further bursts while `enTx` stays high.
- Retrigger ignored: pulse `enTx` low/high at cycle 100 of a burst → burst length is still 512, with one `overTx` pulse.
- Reset mid-burst: assert `rst` at cycle 200 of a burst → `dadata`=128 and state IDLE next cycle; no `overTx`.
- Parameter corners: SAMPLE_DIV=1, NUM_PERIODS=1 → 64 consecutive ROM values, one per clock, and `overTx` on cycle 65.
- With `TX_AUTOREPEAT_EN` defined, `enTx` held high → `overTx` pulses every 513 cycles; `dadata`=128 in each gap cycle.

Source files
------------

// File: rtl/tx_if.sv
// rtl/tx_if.sv - control/DAC bundle for the tx burst transmitter
interface tx_if;
    logic       enTx;
    logic       overTx;
    logic [7:0] dadata;

    modport master (output enTx, input overTx, input dadata);
    modport slave  (input enTx, output overTx, output dadata);
endinterface

// File: rtl/tx.sv
// rtl/tx.sv - DAC sine burst transmitter; optional TX_AUTOREPEAT_EN restarts bursts while enTx stays high
module tx #(
    parameter int SAMPLE_DIV  = 4,
    parameter int NUM_PERIODS = 2
) (
    input  logic clk_100,
    input  logic rst,
    tx_if.slave  bus
);

    localparam int DIV_W = $clog2(SAMPLE_DIV > 2 ? SAMPLE_DIV : 2);
    localparam int PER_W = $clog2(NUM_PERIODS > 2 ? NUM_PERIODS : 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(NUM_PERIODS - 1);
    localparam logic [7:0]       MID      = 8'd128;

    // round(128 + 127*sin(2*pi*k/64))
    localparam logic [7:0] SINE [64] = '{
        8'd128, 8'd140, 8'd153, 8'd165, 8'd177, 8'd188, 8'd199, 8'd209,
        8'd218, 8'd226, 8'd234, 8'd240, 8'd245, 8'd250, 8'd253, 8'd254,
        8'd255, 8'd254, 8'd253, 8'd250, 8'd245, 8'd240, 8'd234, 8'd226,
        8'd218, 8'd209, 8'd199, 8'd188, 8'd177, 8'd165, 8'd153, 8'd140,
        8'd128, 8'd116, 8'd103, 8'd91,  8'd79,  8'd68,  8'd57,  8'd47,
        8'd38,  8'd30,  8'd22,  8'd16,  8'd11,  8'd6,   8'd3,   8'd2,
        8'd1,   8'd2,   8'd3,   8'd6,   8'd11,  8'd16,  8'd22,  8'd30,
        8'd38,  8'd47,  8'd57,  8'd68,  8'd79,  8'd91,  8'd103, 8'd116
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic             en_d;
    logic             start_r;
    logic [5:0]       idx, idx_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [PER_W-1:0] per_cnt, per_n;
    logic [7:0]       dadata_r, dadata_n;
    logic             over_r, over_n;

    assign bus.dadata = dadata_r;
    assign bus.overTx = over_r;

    // Outputs are loaded from the next state so they line up with the state register.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        div_n   = div_cnt;
        per_n   = per_cnt;
        case (state)
            IDLE: begin
                if (start_r) begin
                    state_n = RUN;
                    idx_n   = '0;
                    div_n   = '0;
                    per_n   = '0;
                end
            end
            RUN: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    idx_n = idx + 6'd1;
                    if (idx == 6'd63) begin
                        per_n = per_cnt + 1'b1;
                        if (per_cnt == PER_LAST) begin
                            state_n = DONE;
                            per_n   = '0;
                        end
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            DONE: begin
                idx_n = '0;
                div_n = '0;
                per_n = '0;
`ifdef TX_AUTOREPEAT_EN
                state_n = bus.enTx ? RUN : IDLE;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        dadata_n = (state_n == RUN) ? SINE[idx_n] : MID;
        over_n   = (state_n == DONE);
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            state    <= IDLE;
            en_d     <= 1'b0;
            start_r  <= 1'b0;
            idx      <= '0;
            div_cnt  <= '0;
            per_cnt  <= '0;
            dadata_r <= MID;
            over_r   <= 1'b0;
        end else begin
            state    <= state_n;
            en_d     <= bus.enTx;
            start_r  <= bus.enTx & ~en_d;
            idx      <= idx_n;
            div_cnt  <= div_n;
            per_cnt  <= per_n;
            dadata_r <= dadata_n;
            over_r   <= over_n;
        end
    end

endmodule

// File: tb/tb_tx.sv
// tb/tb_tx.sv - directed bench for tx (default and SAMPLE_DIV=1/NUM_PERIODS=1 instances)
module tb_tx;

    logic clk_100 = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   rom [64];

    tx_if bus0 ();
    tx_if bus1 ();

    tx u0 (.clk_100(clk_100), .rst(rst), .bus(bus0.slave));
    tx #(.SAMPLE_DIV(1), .NUM_PERIODS(1)) u1 (.clk_100(clk_100), .rst(rst), .bus(bus1.slave));

    always #5 clk_100 = ~clk_100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int sel, input string tag);
        if (sel == 0) begin
            chk({tag, " u0 dadata"}, {24'd0, bus0.dadata}, 32'd128);
            chk({tag, " u0 overTx"}, {31'd0, bus0.overTx}, 32'd0);
        end else begin
            chk({tag, " u1 dadata"}, {24'd0, bus1.dadata}, 32'd128);
            chk({tag, " u1 overTx"}, {31'd0, bus1.overTx}, 32'd0);
        end
    endtask

    // Checks len RUN cycles then the DONE cycle; optional enTx low/high blip on u0.
    task automatic burst(input int sel, input int div, input int len, input int retrig_at);
        logic [7:0] d;
        logic       o;
        for (int c = 0; c < len; c++) begin
            @(negedge clk_100);
            d = (sel == 0) ? bus0.dadata : bus1.dadata;
            o = (sel == 0) ? bus0.overTx : bus1.overTx;
            chk($sformatf("run%0d c%0d dadata", sel, c), {24'd0, d}, rom[(c / div) % 64]);
            chk($sformatf("run%0d c%0d overTx", sel, c), {31'd0, o}, 32'd0);
            if (div == 4 && c == 64)  chk("sample16", {24'd0, d}, 32'd255);
            if (div == 4 && c == 192) chk("sample48", {24'd0, d}, 32'd1);
            if (c == retrig_at)     bus0.enTx = 1'b0;
            if (c == retrig_at + 1) bus0.enTx = 1'b1;
        end
        @(negedge clk_100);
        d = (sel == 0) ? bus0.dadata : bus1.dadata;
        o = (sel == 0) ? bus0.overTx : bus1.overTx;
        chk($sformatf("done%0d overTx", sel), {31'd0, o}, 32'd1);
        chk($sformatf("done%0d dadata", sel), {24'd0, d}, 32'd128);
    endtask

    initial begin
        for (int k = 0; k < 64; k++)
            rom[k] = $rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0) + 0.5);

        rst = 1'b1;
        bus0.enTx = 1'b0;
        bus1.enTx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_100);
            chk_idle(0, "reset");
            chk_idle(1, "reset");
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100);
            chk_idle(0, "post_reset");
            chk_idle(1, "post_reset");
        end

        // single burst, enTx held high
        bus0.enTx = 1'b1;
        @(negedge clk_100);
        chk_idle(0, "latency");
        burst(0, 4, 512, -1);
`ifdef TX_AUTOREPEAT_EN
        burst(0, 4, 512, -1);
        bus0.enTx = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100);
            chk_idle(0, "after_repeat");
        end
`else
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_100);
            chk_idle(0, "held_high");
        end
        bus0.enTx = 1'b0;
        @(negedge clk_100);
        chk_idle(0, "en_low");
`endif

        // retrigger inside a burst is ignored
        bus0.enTx = 1'b1;
        @(negedge clk_100);
        chk_idle(0, "retrig latency");
        burst(0, 4, 512, 100);
        bus0.enTx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_100);
            chk_idle(0, "after_retrig");
        end

        // reset mid-burst
        bus0.enTx = 1'b1;
        @(negedge clk_100);
        chk_idle(0, "abort latency");
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_100);
            chk($sformatf("abort c%0d dadata", c), {24'd0, bus0.dadata}, rom[(c / 4) % 64]);
        end
        rst = 1'b1;
        @(negedge clk_100);
        chk_idle(0, "abort");
        rst = 1'b0;
        bus0.enTx = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_100);
            chk_idle(0, "after_abort");
        end

        // SAMPLE_DIV=1, NUM_PERIODS=1 corner
        bus1.enTx = 1'b1;
        @(negedge clk_100);
        chk_idle(1, "corner latency");
        burst(1, 1, 64, -1);
        bus1.enTx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_100);
            chk_idle(1, "after_corner");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
